// File: rtl/random_bit_generator.sv
// rtl/random_bit_generator.sv - Fibonacci LFSR pseudo-random bit source with selectable PRBS polynomial
module random_bit_generator #(
    parameter int          PRBS_ORDER = 7,
    parameter logic [31:0] SEED       = 32'd1
) (
    output logic rand_bit,
    input  logic clk,
    input  logic reset
);

    // Unsupported orders fall back to PRBS7.
    localparam int W = (PRBS_ORDER == 9 || PRBS_ORDER == 15 ||
                        PRBS_ORDER == 23 || PRBS_ORDER == 31) ? PRBS_ORDER : 7;

    localparam int TAP_B = (W == 9)  ? 5  :
                           (W == 15) ? 14 :
                           (W == 23) ? 18 :
                           (W == 31) ? 28 : 6;

    localparam logic [W-1:0] SEED_T   = SEED[W-1:0];
    localparam logic [W-1:0] SEED_EFF = (SEED_T == '0) ? W'(1) : SEED_T;

    logic [W-1:0] state;

    // The leading tap is always the MSB, so feedback is state[W-1] ^ state[TAP_B-1].
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEED_EFF;
        end else if (state == '0) begin
            state <= W'(1);
        end else begin
            state <= {state[W-2:0], state[W-1] ^ state[TAP_B-1]};
        end
    end

    assign rand_bit = state[W-1];

endmodule

// File: tb/tb_random_bit_generator.sv
// tb/tb_random_bit_generator.sv - self-checking bench for random_bit_generator against a recurrence model
module tb_random_bit_generator;

    localparam int NI = 8;

    logic        clk;
    logic        reset;
    logic        obs_rnd [NI];
    logic [31:0] obs_st  [NI];

    int n_assert = 0;
    int n_fail   = 0;

    int          w    [NI] = '{7, 9, 15, 7, 7, 7, 9, 7};
    int          tb_b [NI] = '{6, 5, 14, 6, 6, 6, 5, 6};
    logic [31:0] seed [NI] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd0, 32'd128, 32'h3A5, 32'd1};

    bit win  [NI][$];
    bit hist [NI][32768];
    int ones [NI];

    logic [6:0] ref_state [8] = '{7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000,
                                  7'b0100000, 7'b1000001, 7'b0000011, 7'b0000110};
    logic       ref_rand  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    random_bit_generator #(.PRBS_ORDER(7),  .SEED(32'd1))   u0 (.rand_bit(obs_rnd[0]), .clk(clk), .reset(reset));
    random_bit_generator #(.PRBS_ORDER(9),  .SEED(32'd1))   u1 (.rand_bit(obs_rnd[1]), .clk(clk), .reset(reset));
    random_bit_generator #(.PRBS_ORDER(15), .SEED(32'd1))   u2 (.rand_bit(obs_rnd[2]), .clk(clk), .reset(reset));
    random_bit_generator #(.PRBS_ORDER(5),  .SEED(32'd1))   u3 (.rand_bit(obs_rnd[3]), .clk(clk), .reset(reset));
    random_bit_generator #(.PRBS_ORDER(7),  .SEED(32'd0))   u4 (.rand_bit(obs_rnd[4]), .clk(clk), .reset(reset));
    random_bit_generator #(.PRBS_ORDER(7),  .SEED(32'd128)) u5 (.rand_bit(obs_rnd[5]), .clk(clk), .reset(reset));
    random_bit_generator #(.PRBS_ORDER(9),  .SEED(32'h3A5)) u6 (.rand_bit(obs_rnd[6]), .clk(clk), .reset(reset));
    random_bit_generator #(.PRBS_ORDER(7),  .SEED(32'd1))   u7 (.rand_bit(obs_rnd[7]), .clk(clk), .reset(reset));

    assign obs_st[0] = 32'(u0.state);
    assign obs_st[1] = 32'(u1.state);
    assign obs_st[2] = 32'(u2.state);
    assign obs_st[3] = 32'(u3.state);
    assign obs_st[4] = 32'(u4.state);
    assign obs_st[5] = 32'(u5.state);
    assign obs_st[6] = 32'(u6.state);
    assign obs_st[7] = 32'(u7.state);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s inst=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [31:0] eff_seed(input int k);
        logic [31:0] m;
        m = seed[k] & ((32'd1 << w[k]) - 32'd1);
        return (m == 32'd0) ? 32'd1 : m;
    endfunction

    // The model holds the next W output bits of the sequence; the oldest is the current output.
    function automatic void load(input int k, input logic [31:0] v);
        win[k].delete();
        for (int i = 0; i < w[k]; i++) win[k].push_back(v[w[k]-1-i]);
    endfunction

    function automatic void step(input int k);
        bit nb;
        bit old;
        nb = win[k][0] ^ win[k][w[k]-tb_b[k]];
        win[k].push_back(nb);
        old = win[k].pop_front();
    endfunction

    function automatic logic [31:0] exp_state(input int k);
        logic [31:0] s = '0;
        for (int i = 0; i < w[k]; i++) s = (s << 1) | 32'(win[k][i]);
        return s;
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < NI; k++) begin
            check({tag, "_rand"}, k, 32'(obs_rnd[k]), 32'(win[k][0]));
            check({tag, "_state"}, k, obs_st[k], exp_state(k));
        end
    endtask

    // One clock of free running; track enables period and ones-count bookkeeping.
    task automatic cycle(input int c, input bit track, input bit deposit7);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            if (deposit7 && k == 7) load(7, 32'd1);
            else step(k);
        end
        check_all("seq");
        if (c < 8) begin
            check("req020_rand", 0, 32'(obs_rnd[0]), 32'(ref_rand[c]));
            check("req020_state", 0, obs_st[0], 32'(ref_state[c]));
        end
        if (track) begin
            for (int k = 0; k < 3; k++) begin
                int p = (1 << w[k]) - 1;
                check("nonzero", k, 32'(obs_st[k] != 0), 32'd1);
                if (c < p) begin
                    hist[k][c] = obs_rnd[k];
                    ones[k] += int'(obs_rnd[k]);
                    if (c == p - 1) check("ones_count", k, 32'(ones[k]), 32'(1 << (w[k] - 1)));
                end else if (c < 2 * p) begin
                    check("period", k, 32'(obs_rnd[k]), 32'(hist[k][c - p]));
                end
            end
        end
    endtask

    initial begin
        int extra;
        reset = 1'b1;
        for (int k = 0; k < NI; k++) ones[k] = 0;

        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            load(k, eff_seed(k));
            check("reset_rand", k, 32'(obs_rnd[k]), 32'(eff_seed(k) >> (w[k] - 1)) & 32'd1);
            check("reset_state", k, obs_st[k], eff_seed(k));
        end
        check("seed0_state", 4, obs_st[4], 32'd1);
        check("seed128_state", 5, obs_st[5], 32'd1);
        #2 reset = 1'b0;

        for (int c = 0; c < 32767 + 40; c++) cycle(c, 1'b1, 1'b0);

        extra = int'($urandom_range(1, 50));
        for (int c = 0; c < extra; c++) cycle(100, 1'b0, 1'b0);

        reset = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                check("hold_rand", k, 32'(obs_rnd[k]), 32'(eff_seed(k) >> (w[k] - 1)) & 32'd1);
                check("hold_state", k, obs_st[k], eff_seed(k));
            end
        end
        reset = 1'b0;
        for (int k = 0; k < NI; k++) load(k, eff_seed(k));
        for (int c = 0; c < 40; c++) cycle(c, 1'b0, 1'b0);

        extra = int'($urandom_range(0, 20));
        for (int c = 0; c < extra; c++) cycle(100, 1'b0, 1'b0);
        force u7.state = 7'd0;
        #1 release u7.state;
        cycle(100, 1'b0, 1'b1);
        check("lockup_state", 7, obs_st[7], 32'd1);
        for (int c = 0; c < 20; c++) cycle(100, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/random_bit_generator.md
RANDOM_BIT_GENERATOR -- requirements
Module: random_bit_generator

Interface
REQ-001 Parameter PRBS_ORDER, default 7: polynomial select; legal values 7, 9, 15, 23, 31; any other value SHALL behave as 7.
REQ-002 Parameter SEED, default 1: reset state, truncated to the LFSR width; a truncated value of zero SHALL be replaced by 1.
REQ-003 Port order SHALL be rand, clk, reset, so positional instantiation (rand, clk, reset) connects correctly.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 rand  output  1  pseudo-random bit, registered (driven directly from a flop, no combinational path from any input).

Function
REQ-007 Internal state S SHALL be an LFSR of width W = PRBS_ORDER (effective value per REQ-001), in Fibonacci form, shifting toward the MSB.
REQ-008 Each rising clk edge with reset=0: fb = S[a-1] XOR S[b-1]; S <= {S[W-2:0], fb}.
REQ-009 Taps (a,b) SHALL be: PRBS7 x^7+x^6+1 (7,6); PRBS9 x^9+x^5+1 (9,5); PRBS15 x^15+x^14+1 (15,14); PRBS23 x^23+x^18+1 (23,18); PRBS31 x^31+x^28+1 (31,28).
REQ-010 rand SHALL equal S[W-1] at all times.
REQ-011 Sequence period SHALL be 2^W-1 cycles; within one period rand SHALL be 1 exactly 2^(W-1) times.
REQ-012 The all-zero state is illegal; if S is ever zero at a rising edge with reset=0, next S SHALL be 1 (lock-up recovery) instead of REQ-008.
REQ-013 No enable: the LFSR advances on every non-reset rising edge.
REQ-014 Latency: the first post-reset shifted bit appears on rand one cycle after the first rising edge sampling reset=0.

Reset
REQ-015 On a rising edge with reset=1, S SHALL load the effective SEED; rand SHALL then equal SEED[W-1] (0 for defaults).
REQ-016 While reset is held high, S and rand SHALL remain constant at seed values.
REQ-017 Reset asserted mid-sequence SHALL restart the sequence identically to the first post-reset sequence.
REQ-018 Reset has priority over lock-up recovery and normal shifting.
REQ-019 Before the first reset edge, S is undefined; no output value is guaranteed.

Verification
REQ-020 Default params, clk period 10, reset=1 until t=12 -> rand=0 after first edge; post-reset state sequence 0000010, 0000100, 0001000, 0010000, 0100000, 1000001, 0000011, 0000110; rand = 0,0,0,0,0,1,0,0.
REQ-021 Default params, run 254 cycles after reset -> rand sequence repeats with period exactly 127; 64 ones per period; S never 0.
REQ-022 Reset re-asserted t=102..114 after free running -> rand=0 while held; following bit stream matches REQ-020 from its start.
REQ-023 Reset held for 10 consecutive edges -> rand stays 0 and S stays 0000001 throughout.
REQ-024 PRBS_ORDER=9, 15 (SEED=1) -> measured periods 511 and 32767, ones counts 256 and 16384; PRBS_ORDER=5 -> identical output to PRBS_ORDER=7.
REQ-025 Force S to 0 (hierarchical deposit) with reset=0 -> next edge S=1, then normal sequence resumes; SEED=0 or SEED=128 with W=7 -> reset state 0000001.
